// File: rtl/mem_resp_pkg.sv
// Shared types for the memory responder: FSM states, captured request kinds
// and the width of the wait-state counter.
package mem_resp_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    typedef enum logic [1:0] {
        REQ_IFETCH,
        REQ_DLOAD,
        REQ_DSTORE,
        REQ_ERR
    } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Strobe/address/data bundle between the control unit (master) and the
// memory responder (slave).
interface mem_responder_if;

    logic        IMemRead;
    logic [63:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        DMemRead;
    logic        DMemWrite;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_ready;
    logic        d_err;

    modport master (
        output IMemRead, i_addr, DMemRead, DMemWrite, d_addr, d_wdata,
        input  i_rdata, i_ready, d_rdata, d_ready, d_err
    );

    modport slave (
        input  IMemRead, i_addr, DMemRead, DMemWrite, d_addr, d_wdata,
        output i_rdata, i_ready, d_rdata, d_ready, d_err
    );

endinterface

// File: rtl/mem_resp_array.sv
// Storage array with a synchronous write port and a registered read port.
// The read register is the response data seen by the requester: it only
// changes on a read enable or an explicit clear, so it holds between responses.
module mem_resp_array #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic             clr,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**IDX_W];

    // Array contents: written on request, never cleared by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Response register: loaded on a read, zeroed on an error response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the multicycle control unit: serves instruction
// fetches and 64-bit loads/stores after WAIT_CYCLES wait states and answers
// with a one-cycle ready pulse.
// Optional feature: define MEM_RESP_PERF_EN to add saturating performance
// counters perf_reads, perf_writes and perf_stalls.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int IDX_W       = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MEM_RESP_PERF_EN
    output logic [31:0] perf_reads,
    output logic [31:0] perf_writes,
    output logic [31:0] perf_stalls,
`endif
    mem_responder_if.slave bus
);

    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [WAIT_W-1:0] LAST_WAIT =
        (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    mem_state_t        state;
    mem_req_t          reqType;
    logic [WAIT_W-1:0] waitCnt;
    logic [IDX_W-1:0]  iIdxCap;
    logic [IDX_W-1:0]  dIdxCap;
    logic [63:0]       wdataCap;

    mem_req_t          reqNow;
    mem_req_t          respType;
    logic              reqValid;
    logic              strobeHeld;
    logic              enterResp;
    logic [IDX_W-1:0]  iIdxNow;
    logic [IDX_W-1:0]  dIdxNow;
    logic [IDX_W-1:0]  iRaddr;
    logic [IDX_W-1:0]  dRaddr;
    logic              iRe;
    logic              dRe;
    logic              dClr;
    logic              dWe;
    logic [31:0]       iArrRdata;
    logic [63:0]       dArrRdata;
    logic              unusedAddrBits;

    assign iIdxNow  = bus.i_addr[IDX_W+1:2];
    assign dIdxNow  = bus.d_addr[IDX_W+2:3];
    assign reqValid = bus.IMemRead | bus.DMemRead | bus.DMemWrite;

    // Address bits outside the index window are ignored (addresses wrap).
    assign unusedAddrBits = ^{bus.i_addr[63:IDX_W+2], bus.i_addr[1:0],
                              bus.d_addr[63:IDX_W+3]};

    // Classify the live strobes: data beats instruction, read+write or a
    // misaligned data address become an error request.
    always_comb begin
        reqNow = REQ_IFETCH;
        if (bus.DMemRead && bus.DMemWrite) begin
            reqNow = REQ_ERR;
        end else if (bus.DMemRead || bus.DMemWrite) begin
            if (bus.d_addr[2:0] != 3'b000) begin
                reqNow = REQ_ERR;
            end else if (bus.DMemWrite) begin
                reqNow = REQ_DSTORE;
            end else begin
                reqNow = REQ_DLOAD;
            end
        end
    end

    // Is the strobe that started the captured request still asserted?
    always_comb begin
        strobeHeld = 1'b0;
        case (reqType)
            REQ_IFETCH: strobeHeld = bus.IMemRead;
            REQ_DLOAD:  strobeHeld = bus.DMemRead;
            REQ_DSTORE: strobeHeld = bus.DMemWrite;
            default:    strobeHeld = bus.DMemRead | bus.DMemWrite;
        endcase
    end

    // With no wait states the response is launched straight from IDLE using
    // the live request; otherwise from the last WAIT cycle using the capture.
    assign enterResp = (state == IDLE && reqValid && NO_WAIT) ||
                       (state == WAIT && strobeHeld && waitCnt == LAST_WAIT);
    assign respType  = (state == IDLE) ? reqNow : reqType;
    assign iRaddr    = (state == IDLE) ? iIdxNow : iIdxCap;
    assign dRaddr    = (state == IDLE) ? dIdxNow : dIdxCap;
    assign iRe       = enterResp && respType == REQ_IFETCH;
    assign dRe       = enterResp && respType == REQ_DLOAD;
    assign dClr      = enterResp && respType == REQ_ERR;
    // Stores commit only at the end of RESP, so aborts and resets drop them.
    assign dWe       = state == RESP && reqType == REQ_DSTORE;

    // Request FSM with wait counter and registered ready/error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            reqType     <= REQ_IFETCH;
            waitCnt     <= '0;
            bus.i_ready <= 1'b0;
            bus.d_ready <= 1'b0;
            bus.d_err   <= 1'b0;
        end else begin
            bus.i_ready <= enterResp && respType == REQ_IFETCH;
            bus.d_ready <= enterResp && respType != REQ_IFETCH;
            bus.d_err   <= enterResp && respType == REQ_ERR;
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        reqType <= reqNow;
                        waitCnt <= '0;
                        state   <= NO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!strobeHeld) begin
                        state <= IDLE;
                    end else if (waitCnt == LAST_WAIT) begin
                        state <= RESP;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Address and store-data capture when a request is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (state == IDLE && reqValid) begin
            iIdxCap  <= iIdxNow;
            dIdxCap  <= dIdxNow;
            wdataCap <= bus.d_wdata;
        end
    end

    mem_resp_array #(.WIDTH(32), .IDX_W(IDX_W)) uInstrArray (
        .clk   (clk),
        .reset (reset),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .re    (iRe),
        .clr   (1'b0),
        .raddr (iRaddr),
        .rdata (iArrRdata)
    );

    mem_resp_array #(.WIDTH(64), .IDX_W(IDX_W)) uDataArray (
        .clk   (clk),
        .reset (reset),
        .we    (dWe),
        .waddr (dIdxCap),
        .wdata (wdataCap),
        .re    (dRe),
        .clr   (dClr),
        .raddr (dRaddr),
        .rdata (dArrRdata)
    );

    assign bus.i_rdata = iArrRdata;
    assign bus.d_rdata = dArrRdata;

`ifdef MEM_RESP_PERF_EN
    // Saturating counters: completed non-error reads/writes and WAIT cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_reads  <= '0;
            perf_writes <= '0;
            perf_stalls <= '0;
        end else begin
            if (state == RESP && (reqType == REQ_IFETCH || reqType == REQ_DLOAD)
                && perf_reads != '1) begin
                perf_reads <= perf_reads + 32'd1;
            end
            if (state == RESP && reqType == REQ_DSTORE && perf_writes != '1) begin
                perf_writes <= perf_writes + 32'd1;
            end
            if (state == WAIT && perf_stalls != '1) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (default build, WAIT_CYCLES = 2).
// A reference model of both arrays and of the last returned read data on
// each port predicts every response.
module tb_mem_responder;

    localparam int IDX_W       = 6;
    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH       = 1 << IDX_W;
    localparam int EXP_LAT     = 1 + WAIT_CYCLES;
    localparam int MAX_WAIT    = 40;

    logic clk = 1'b0;
    logic reset;

    mem_responder_if bus ();

    mem_responder #(.IDX_W(IDX_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] instrModel [DEPTH];
    logic [63:0] dataModel  [DEPTH];
    logic [31:0] lastI = '0;
    logic [63:0] lastD = '0;

    // Issue one request, wait (bounded) for its ready pulse, then spend one
    // cycle with strobes low and report whether any ready/err is still high.
    task automatic runReq(input logic iR, input logic dR, input logic dW,
                          input logic [63:0] ia, input logic [63:0] da,
                          input logic [63:0] wd, output int lat,
                          output logic [3:0] hs, output logic [31:0] ir,
                          output logic [63:0] dr);
        logic gotI, gotD, gotErr;
        gotI = 1'b0; gotD = 1'b0; gotErr = 1'b0; ir = '0; dr = '0;
        bus.IMemRead = iR; bus.DMemRead = dR; bus.DMemWrite = dW;
        bus.i_addr = ia; bus.d_addr = da; bus.d_wdata = wd;
        lat = 0;
        while (lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
            if (bus.i_ready || bus.d_ready) begin
                gotI = bus.i_ready; gotD = bus.d_ready; gotErr = bus.d_err;
                ir = bus.i_rdata; dr = bus.d_rdata;
                break;
            end
        end
        bus.IMemRead = 1'b0; bus.DMemRead = 1'b0; bus.DMemWrite = 1'b0;
        @(posedge clk); #1;
        hs = {gotI, gotD, gotErr, bus.i_ready | bus.d_ready | bus.d_err};
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.i_ready, bus.d_ready, bus.d_err, bus.i_rdata, bus.d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b/%b err=%b irdata=%h drdata=%h, required all 0",
                     bus.i_ready, bus.d_ready, bus.d_err, bus.i_rdata, bus.d_rdata);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.i_ready, bus.d_ready, bus.d_err} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got ready/ready/err=%b%b%b, required 000",
                     bus.i_ready, bus.d_ready, bus.d_err);
        end
    endtask

    task automatic test_fill();
        int lat, bad;
        logic [3:0] hs; logic [31:0] ir; logic [63:0] dr;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            dataModel[i] = {$urandom, $urandom} | 64'h1;
            runReq(1'b0, 1'b0, 1'b1, 64'h0, 64'(i) << 3, dataModel[i], lat, hs, ir, dr);
            if (lat != EXP_LAT || hs != 4'b0100 || dr !== lastD) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fill_stores: got %0d bad store responses, required 0", bad);
        end
    endtask

    task automatic test_fetch();
        int lat;
        logic [3:0] hs; logic [31:0] ir; logic [63:0] dr;
        runReq(1'b1, 1'b0, 1'b0, 64'd12, 64'h0, 64'h0, lat, hs, ir, dr);
        checks++;
        if (lat != EXP_LAT || hs != 4'b1000) begin
            errors++;
            $display("FAIL fetch_handshake: got lat=%0d hs=%b, required lat=%0d hs=1000", lat, hs, EXP_LAT);
        end
        checks++;
        if (ir !== 32'h00A30313 || dr !== lastD) begin
            errors++;
            $display("FAIL fetch_data: got i=%h d=%h, required i=00a30313 d=%h", ir, dr, lastD);
        end
        lastI = ir;
    endtask

    task automatic test_store_load();
        int lat;
        logic [3:0] hs; logic [31:0] ir; logic [63:0] dr;
        runReq(1'b0, 1'b0, 1'b1, 64'h0, 64'd16, 64'hDEAD_BEEF_0123_4567, lat, hs, ir, dr);
        dataModel[2] = 64'hDEAD_BEEF_0123_4567;
        checks++;
        if (lat != EXP_LAT || hs != 4'b0100) begin
            errors++;
            $display("FAIL store_handshake: got lat=%0d hs=%b, required lat=%0d hs=0100", lat, hs, EXP_LAT);
        end
        runReq(1'b0, 1'b1, 1'b0, 64'h0, 64'd16, 64'h0, lat, hs, ir, dr);
        checks++;
        if (lat != EXP_LAT || hs != 4'b0100 || dr !== 64'hDEAD_BEEF_0123_4567 || ir !== lastI) begin
            errors++;
            $display("FAIL load_after_store: got lat=%0d hs=%b d=%h i=%h, required d=deadbeef01234567 i=%h",
                     lat, hs, dr, ir, lastI);
        end
        lastD = dr;
    endtask

    task automatic test_misaligned();
        int lat;
        logic [3:0] hs; logic [31:0] ir; logic [63:0] dr;
        runReq(1'b0, 1'b0, 1'b1, 64'h0, 64'd20, 64'h1111_2222_3333_4444, lat, hs, ir, dr);
        checks++;
        if (lat != EXP_LAT || hs != 4'b0110 || dr !== 64'h0) begin
            errors++;
            $display("FAIL misaligned_store: got lat=%0d hs=%b d=%h, required hs=0110 d=0", lat, hs, dr);
        end
        lastD = '0;
        runReq(1'b0, 1'b1, 1'b0, 64'h0, 64'd16, 64'h0, lat, hs, ir, dr);
        checks++;
        if (hs != 4'b0100 || dr !== dataModel[2]) begin
            errors++;
            $display("FAIL load_after_misaligned: got hs=%b d=%h, required hs=0100 d=%h", hs, dr, dataModel[2]);
        end
        lastD = dr;
    endtask

    task automatic test_abort();
        int lat, seen;
        logic [3:0] hs; logic [31:0] ir; logic [63:0] dr;
        bus.DMemWrite = 1'b1; bus.d_addr = 64'd8; bus.d_wdata = ~dataModel[1];
        @(posedge clk); #1;
        bus.DMemWrite = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus.i_ready || bus.d_ready || bus.d_err) seen++;
        end
        checks++;
        if (seen != 0 || bus.d_rdata !== lastD) begin
            errors++;
            $display("FAIL abort_quiet: got %0d ready cycles d=%h, required 0 and d=%h", seen, bus.d_rdata, lastD);
        end
        runReq(1'b0, 1'b1, 1'b0, 64'h0, 64'd8, 64'h0, lat, hs, ir, dr);
        checks++;
        if (lat != EXP_LAT || dr !== dataModel[1]) begin
            errors++;
            $display("FAIL abort_no_write: got lat=%0d d=%h, required lat=%0d d=%h", lat, dr, EXP_LAT, dataModel[1]);
        end
        lastD = dr;
    endtask

    task automatic test_priority();
        int lat, idxI, idxD;
        logic [3:0] hs; logic [31:0] ir; logic [63:0] dr;
        idxI = $urandom_range(0, DEPTH - 1);
        idxD = $urandom_range(0, DEPTH - 1);
        bus.IMemRead = 1'b1; bus.DMemRead = 1'b1;
        bus.i_addr = 64'(idxI) << 2; bus.d_addr = 64'(idxD) << 3;
        lat = 0;
        while (lat < MAX_WAIT) begin
            @(posedge clk); #1; lat++;
            if (bus.i_ready || bus.d_ready) break;
        end
        checks++;
        if (lat != EXP_LAT || {bus.d_ready, bus.i_ready, bus.d_err} !== 3'b100
            || bus.d_rdata !== dataModel[idxD]) begin
            errors++;
            $display("FAIL priority_data_first: got lat=%0d d/i/err=%b%b%b d=%h, required lat=%0d 100 d=%h",
                     lat, bus.d_ready, bus.i_ready, bus.d_err, bus.d_rdata, EXP_LAT, dataModel[idxD]);
        end
        lastD = dataModel[idxD];
        bus.DMemRead = 1'b0;
        lat = 0;
        while (lat < MAX_WAIT) begin
            @(posedge clk); #1; lat++;
            if (bus.i_ready || bus.d_ready) break;
        end
        checks++;
        if (lat != EXP_LAT + 1 || !bus.i_ready || bus.d_ready || bus.i_rdata !== instrModel[idxI]) begin
            errors++;
            $display("FAIL priority_fetch_after: got lat=%0d i=%b d=%b idata=%h, required lat=%0d i=1 d=0 idata=%h",
                     lat, bus.i_ready, bus.d_ready, bus.i_rdata, EXP_LAT + 1, instrModel[idxI]);
        end
        lastI = instrModel[idxI];
        bus.IMemRead = 1'b0;
        @(posedge clk); #1;
        runReq(1'b0, 1'b1, 1'b1, 64'h0, 64'(idxD) << 3, ~dataModel[idxD], lat, hs, ir, dr);
        checks++;
        if (lat != EXP_LAT || hs != 4'b0110 || dr !== 64'h0) begin
            errors++;
            $display("FAIL illegal_rw: got lat=%0d hs=%b d=%h, required hs=0110 d=0", lat, hs, dr);
        end
        lastD = '0;
        runReq(1'b0, 1'b1, 1'b0, 64'h0, 64'(idxD) << 3, 64'h0, lat, hs, ir, dr);
        checks++;
        if (dr !== dataModel[idxD]) begin
            errors++;
            $display("FAIL illegal_no_write: got d=%h, required %h", dr, dataModel[idxD]);
        end
        lastD = dr;
    endtask

    task automatic test_reset_mid_wait();
        int lat, idx;
        logic [3:0] hs; logic [31:0] ir; logic [63:0] dr;
        idx = $urandom_range(0, DEPTH - 1);
        runReq(1'b1, 1'b0, 1'b0, 64'(idx) << 2, 64'h0, 64'h0, lat, hs, ir, dr);
        lastI = ir;
        bus.DMemWrite = 1'b1; bus.d_addr = 64'(idx) << 3; bus.d_wdata = ~dataModel[idx];
        @(posedge clk); #1;
        reset = 1'b0;
        bus.DMemWrite = 1'b0;
        #1;
        checks++;
        if ({bus.i_ready, bus.d_ready, bus.d_err, bus.i_rdata, bus.d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: got ready=%b/%b err=%b i=%h d=%h, required all 0 (i was %h)",
                     bus.i_ready, bus.d_ready, bus.d_err, bus.i_rdata, bus.d_rdata, lastI);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        lastI = '0; lastD = '0;
        runReq(1'b0, 1'b1, 1'b0, 64'h0, 64'(idx) << 3, 64'h0, lat, hs, ir, dr);
        checks++;
        if (lat != EXP_LAT || dr !== dataModel[idx] || ir !== 32'h0) begin
            errors++;
            $display("FAIL reset_discards_store: got lat=%0d d=%h i=%h, required d=%h i=0", lat, dr, ir, dataModel[idx]);
        end
        lastD = dr;
    endtask

    task automatic test_back_to_back_random();
        int lat, kind, idx, bad;
        logic [3:0] hs, expHs; logic [31:0] ir; logic [63:0] dr, ia, da, wd;
        logic iR, dR, dW;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            idx  = $urandom_range(0, DEPTH - 1);
            ia = {$urandom, $urandom}; da = {$urandom, $urandom}; wd = {$urandom, $urandom};
            ia[IDX_W+1:2] = idx[IDX_W-1:0];
            da[IDX_W+2:3] = idx[IDX_W-1:0];
            iR = 1'b0; dR = 1'b0; dW = 1'b0;
            case (kind)
                0: begin iR = 1'b1; expHs = 4'b1000; end
                1: begin dR = 1'b1; da[2:0] = 3'b000; expHs = 4'b0100; end
                2: begin dW = 1'b1; da[2:0] = 3'b000; expHs = 4'b0100; end
                default: begin
                    dR = $urandom_range(0, 1); dW = ~dR;
                    da[2:0] = 3'($urandom_range(1, 7)); expHs = 4'b0110;
                end
            endcase
            runReq(iR, dR, dW, ia, da, wd, lat, hs, ir, dr);
            case (kind)
                0: lastI = instrModel[idx];
                1: lastD = dataModel[idx];
                2: dataModel[idx] = wd;
                default: lastD = '0;
            endcase
            bad = 0;
            if (lat != EXP_LAT) bad++;
            if (hs != expHs) bad++;
            if (ir !== lastI) bad++;
            if (dr !== lastD) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random_txn_%0d kind=%0d idx=%0d: got lat=%0d hs=%b i=%h d=%h, required lat=%0d hs=%b i=%h d=%h",
                         n, kind, idx, lat, hs, ir, dr, EXP_LAT, expHs, lastI, lastD);
            end
        end
    endtask

    initial begin
        bus.IMemRead = 1'b0; bus.DMemRead = 1'b0; bus.DMemWrite = 1'b0;
        bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            instrModel[i] = $urandom | 32'h1;
        end
        instrModel[3] = 32'h00A30313;
        for (int i = 0; i < DEPTH; i++) begin
            dut.uInstrArray.mem[i] = instrModel[i];
        end
        test_reset();
        test_fill();
        test_fetch();
        test_store_load();
        test_misaligned();
        test_abort();
        test_priority();
        test_reset_mid_wait();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
